// File: rtl/data_mem_pkg.sv
// Shared types and constants for the parametrised data memory.
//   mem_state_t   : clear sequencer state (idle / sweeping)
//   READ_LAT_*    : legal values of the READ_LAT parameter
package data_mem_pkg;

  typedef enum logic {MS_IDLE = 1'b0, MS_CLEAR = 1'b1} mem_state_t;

  localparam int unsigned READ_LAT_COMB = 0;
  localparam int unsigned READ_LAT_REG  = 1;

endpackage

// File: rtl/mem_clear_seq.sv
// Clear sequencer: sweeps every word of the array to zero, either after reset
// (CLEAR_ON_RESET=1) or on a single-cycle ClearReq.
// Ports:
//   Clk, Reset   : clock, synchronous active-low reset
//   ClearReq     : request a sweep (ignored while one is running)
//   Busy         : sweep in progress
//   clear_we     : write strobe for the zeroing write
//   clear_addr   : word being zeroed this cycle
//   clear_start  : pulses on the cycle a ClearReq is accepted
module mem_clear_seq
  import data_mem_pkg::*;
#(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ClearReq,
  output logic              Busy,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              clear_start
);

  // Pointer is one bit wider than the address so DEPTH=2**ADDR_W needs no wrap case.
  localparam logic [ADDR_W:0] LastPtr    = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PtrOne     = (ADDR_W + 1)'(1);
  localparam mem_state_t      ResetState = (CLEAR_ON_RESET != 0) ? MS_CLEAR : MS_IDLE;

  mem_state_t        state_q, state_d;
  logic [ADDR_W:0]   clr_ptr_q, clr_ptr_d;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= ResetState;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    clear_start = 1'b0;
    unique case (state_q)
      MS_IDLE: begin
        if (ClearReq) begin
          state_d     = MS_CLEAR;
          clr_ptr_d   = '0;
          clear_start = 1'b1;
        end
      end
      MS_CLEAR: begin
        clr_ptr_d = clr_ptr_q + PtrOne;
        if (clr_ptr_q == LastPtr) begin
          state_d = MS_IDLE;
        end
      end
      default: state_d = MS_IDLE;
    endcase
  end

  assign Busy       = (state_q == MS_CLEAR);
  assign clear_we   = Busy;
  assign clear_addr = clr_ptr_q[ADDR_W-1:0];

endmodule

// File: rtl/data_mem_p.sv
// Parametrised single-port data memory with hardware clear sweep.
// Ports:
//   Clk, Reset    : clock, synchronous active-low reset
//   WriteEn       : write DataIn to DataAddress (dropped while Busy)
//   ReadEn        : read strobe; qualifies ReadValid
//   ClearReq      : start a zeroing sweep of the whole array
//   DataAddress   : shared read/write address
//   DataIn        : write data
//   DataOut       : read data (combinational or registered per READ_LAT)
//   ReadValid     : DataOut holds a completed read
//   Busy          : clear sweep running, user accesses not serviced
//   WriteDropped  : sticky, a write arrived while Busy
module data_mem_p
  import data_mem_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned READ_LAT       = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WriteEn,
  input  logic              ReadEn,
  input  logic              ClearReq,
  input  logic [ADDR_W-1:0] DataAddress,
  input  logic [WIDTH-1:0]  DataIn,
  output logic [WIDTH-1:0]  DataOut,
  output logic              ReadValid,
  output logic              Busy,
  output logic              WriteDropped
);

  localparam int unsigned     IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  if (!((READ_LAT == READ_LAT_COMB) || (READ_LAT == READ_LAT_REG))) begin : g_bad_lat
    $error("data_mem_p: READ_LAT must be 0 or 1");
  end
  if ((DEPTH < 1) || (64'(DEPTH) > (64'(1) << ADDR_W))) begin : g_bad_depth
    $error("data_mem_p: DEPTH must be in 1..2**ADDR_W");
  end

  logic              clear_we;
  logic              clear_start;
  logic [ADDR_W-1:0] clear_addr;

  mem_clear_seq #(
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .Clk         (Clk),
    .Reset       (Reset),
    .ClearReq    (ClearReq),
    .Busy        (Busy),
    .clear_we    (clear_we),
    .clear_addr  (clear_addr),
    .clear_start (clear_start)
  );

  logic [WIDTH-1:0] core [DEPTH];

  logic            in_range;
  logic [IdxW-1:0] idx;
  logic [IdxW-1:0] clr_idx;
  logic            user_we;
  logic [WIDTH-1:0] rd_word;

  // Out-of-range addresses must never alias onto a real word.
  assign in_range = ({1'b0, DataAddress} < DepthW);
  assign idx      = IdxW'(DataAddress);
  assign clr_idx  = IdxW'(clear_addr);
  assign user_we  = WriteEn & ~Busy & in_range;
  assign rd_word  = in_range ? core[idx] : '0;

  // Array has no reset; the sweep is the only way to give it known contents.
  always_ff @(posedge Clk) begin
    if (clear_we) begin
      core[clr_idx] <= '0;
    end else if (user_we) begin
      core[idx] <= DataIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      WriteDropped <= 1'b0;
    end else if (clear_start) begin
      WriteDropped <= 1'b0;
    end else if (WriteEn && Busy) begin
      WriteDropped <= 1'b1;
    end
  end

  if (READ_LAT == READ_LAT_COMB) begin : g_comb
    // Read-old: a same-cycle write lands only at the edge.
    assign DataOut   = Busy ? '0 : rd_word;
    assign ReadValid = ReadEn & ~Busy;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q;
    logic             rv_q;
    logic [WIDTH-1:0] rd_next;

    // Write-first bypass for a same-cycle write to the shared address.
    assign rd_next = (WriteEn && in_range) ? DataIn : rd_word;

    always_ff @(posedge Clk) begin
      if (!Reset) begin
        dout_q <= '0;
        rv_q   <= 1'b0;
      end else begin
        rv_q <= ReadEn & ~Busy;
        if (ReadEn && !Busy) begin
          dout_q <= rd_next;
        end
      end
    end

    assign DataOut   = dout_q;
    assign ReadValid = rv_q;
  end

endmodule

// File: tb/tb_data_mem_p.sv
// Scoreboard bench: three instances (defaults, READ_LAT=0, DEPTH=200) share one
// stimulus stream; a word-array model predicts every read, Busy and WriteDropped.
module tb_data_mem_p;

  logic       clk;
  logic       rst_n, we, re, clr;
  logic [7:0] addr, din;

  logic [7:0] a_dout, z_dout, b_dout;
  logic       a_rv, z_rv, b_rv;
  logic       a_busy, z_busy, b_busy;
  logic       a_drop, z_drop, b_drop;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  data_mem_p u_dut (
    .Clk(clk), .Reset(rst_n), .WriteEn(we), .ReadEn(re), .ClearReq(clr),
    .DataAddress(addr), .DataIn(din), .DataOut(a_dout), .ReadValid(a_rv),
    .Busy(a_busy), .WriteDropped(a_drop)
  );

  data_mem_p #(.READ_LAT(0)) u_lat0 (
    .Clk(clk), .Reset(rst_n), .WriteEn(we), .ReadEn(re), .ClearReq(clr),
    .DataAddress(addr), .DataIn(din), .DataOut(z_dout), .ReadValid(z_rv),
    .Busy(z_busy), .WriteDropped(z_drop)
  );

  data_mem_p #(.DEPTH(200), .ADDR_W(8)) u_d200 (
    .Clk(clk), .Reset(rst_n), .WriteEn(we), .ReadEn(re), .ClearReq(clr),
    .DataAddress(addr), .DataIn(din), .DataOut(b_dout), .ReadValid(b_rv),
    .Busy(b_busy), .WriteDropped(b_drop)
  );

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  // Queue 0: u_dut, 1: u_lat0, 2: u_d200.
  exp_t q [3][$];

  // Model 0 covers the 256-word instances, model 1 the 200-word one.
  // A clear is modelled as an instant zeroing plus a busy window of DEPTH cycles.
  logic [7:0] mem   [2][256];
  int         rem   [2];
  bit         drop  [2];
  logic [7:0] dout1 [2];
  int         dep   [2];

  int checks = 0;
  int errors = 0;
  int cnt    = 0;
  bit armed  = 0;

  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cnt);
    end
  endtask

  task automatic model_edge(input int m);
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[m][i] = 8'h00;
      rem[m]   = dep[m];
      drop[m]  = 1'b0;
      dout1[m] = 8'h00;
    end else if (rem[m] > 0) begin
      if (we) drop[m] = 1'b1;
      rem[m]--;
    end else begin
      if (re) dout1[m] = (int'(addr) < dep[m]) ? (we ? din : mem[m][addr]) : 8'h00;
      if (we && int'(addr) < dep[m]) mem[m][addr] = din;
      if (clr) begin
        for (int i = 0; i < 256; i++) mem[m][i] = 8'h00;
        rem[m]  = dep[m];
        drop[m] = 1'b0;
      end
    end
  endtask

  task automatic push_exp();
    exp_t e;
    if (re && rem[0] == 0) begin
      e.data = mem[0][addr];
      e.due  = cnt;
      q[1].push_back(e);
      if (rst_n) begin
        e.data = we ? din : mem[0][addr];
        e.due  = cnt + 1;
        q[0].push_back(e);
      end
    end
    if (re && rem[1] == 0 && rst_n) begin
      e.data = (int'(addr) < dep[1]) ? (we ? din : mem[1][addr]) : 8'h00;
      e.due  = cnt + 1;
      q[2].push_back(e);
    end
  endtask

  // Called just after a rising edge; leaves time just after the next one.
  task automatic cyc(input bit r, input bit w, input bit rd, input bit c,
                     input logic [7:0] a, input logic [7:0] d);
    rst_n = r; we = w; re = rd; clr = c; addr = a; din = d;
    if (armed) begin
      chk("busy_a", a_busy, rem[0] > 0);
      chk("busy_z", z_busy, rem[0] > 0);
      chk("busy_b", b_busy, rem[1] > 0);
      chk("drop_a", a_drop, drop[0]);
      chk("drop_z", z_drop, drop[0]);
      chk("drop_b", b_drop, drop[1]);
      chk("hold_a", a_dout, dout1[0]);
      chk("hold_b", b_dout, dout1[1]);
    end
    push_exp();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    armed = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic mon(input int k, input logic rv, input logic [7:0] dv);
    exp_t e;
    if (rv === 1'b1) begin
      if (q[k].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rv_unexpected[%0d] actual=1 required=0 (cycle %0d)", k, cnt);
      end else begin
        e = q[k].pop_front();
        chk($sformatf("rdata[%0d]", k), dv, e.data);
        chk($sformatf("rlat[%0d]", k), cnt, e.due);
      end
    end else begin
      chk($sformatf("rv_known[%0d]", k), rv, 0);
      if (q[k].size() > 0 && q[k][0].due <= cnt) begin
        checks++;
        errors++;
        $display("FAIL rv_missing[%0d] actual=0 required=1 (cycle %0d)", k, cnt);
        e = q[k].pop_front();
      end
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      mon(0, a_rv, a_dout);
      mon(1, z_rv, z_dout);
      mon(2, b_rv, b_dout);
    end
  end

  initial begin
    int na, nb;
    logic [7:0] ra;
    rst_n = 1'b0; we = 1'b0; re = 1'b0; clr = 1'b0; addr = 8'h00; din = 8'h00;
    dep[0] = 256;
    dep[1] = 200;
    for (int m = 0; m < 2; m++) begin
      rem[m] = 1; drop[m] = 1'b0; dout1[m] = 8'h00;
      for (int i = 0; i < 256; i++) mem[m][i] = 8'h00;
    end
    @(posedge clk);
    #1;

    // Reset for one cycle, then time the automatic sweep.
    cyc(0, 0, 0, 0, 8'h00, 8'h00);
    na = 0; nb = 0;
    for (int i = 0; i < 300; i++) begin
      if (a_busy) na++;
      if (b_busy) nb++;
      idle(1);
    end
    chk("sweep_len_256", na, 256);
    chk("sweep_len_200", nb, 200);

    cyc(1, 0, 1, 0, 8'd16, 8'h00);
    idle(1);

    cyc(1, 1, 0, 0, 8'd16, 8'hFE);
    cyc(1, 1, 0, 0, 8'd244, 8'h05);
    cyc(1, 0, 1, 0, 8'd16, 8'h00);
    cyc(1, 0, 1, 0, 8'd244, 8'h00);
    idle(2);

    // Same-cycle write+read: registered returns new data, combinational returns old.
    cyc(1, 1, 0, 0, 8'd7, 8'h11);
    cyc(1, 1, 1, 0, 8'd7, 8'hA5);
    cyc(1, 0, 1, 0, 8'd7, 8'h00);
    idle(2);

    // Write during sweep is dropped; a second ClearReq mid-sweep is ignored.
    cyc(1, 1, 0, 0, 8'd3, 8'h44);
    cyc(1, 0, 0, 1, 8'h00, 8'h00);
    idle(10);
    cyc(1, 1, 0, 0, 8'd3, 8'h33);
    chk("drop_set", a_drop, 1);
    idle(40);
    cyc(1, 0, 0, 1, 8'h00, 8'h00);
    idle(220);
    chk("drop_sticky", a_drop, 1);
    cyc(1, 0, 1, 0, 8'd3, 8'h00);
    idle(2);

    // Reset mid-sweep restarts a full sweep.
    cyc(1, 1, 0, 0, 8'd200, 8'h77);
    cyc(0, 0, 0, 0, 8'h00, 8'h00);
    idle(100);
    cyc(0, 0, 0, 0, 8'h00, 8'h00);
    na = 0;
    for (int i = 0; i < 300; i++) begin
      if (a_busy) na++;
      idle(1);
    end
    chk("sweep_restart", na, 256);
    cyc(1, 0, 1, 0, 8'd200, 8'h00);
    idle(2);

    // Out-of-range write on the 200-word instance must not alias.
    cyc(1, 1, 0, 0, 8'd10, 8'h5A);
    cyc(1, 1, 0, 0, 8'd210, 8'h99);
    cyc(1, 0, 1, 0, 8'd210, 8'h00);
    cyc(1, 0, 1, 0, 8'd10, 8'h00);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      ra = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15))
                                       : 8'($urandom_range(190, 255));
      cyc($urandom_range(0, 999) != 0, $urandom_range(0, 1) != 0,
          $urandom_range(0, 1) != 0, $urandom_range(0, 299) == 0,
          ra, 8'($urandom_range(0, 255)));
    end
    idle(3);

    for (int k = 0; k < 3; k++) chk($sformatf("queue_empty[%0d]", k), q[k].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
